// File: rtl/inst_encoder.sv
// ----------------------------------------------------------------------------
// inst_encoder
//
// Packs LOAD / STORE / BRANCH requests into 32-bit RV32I instruction words
// and tags every emitted word with a running instruction address.
//
// A single output register sits between a valid/ready request port and a
// valid/ready instruction port. When the consumer is ready, a new request is
// accepted on the same edge as the current word leaves, so back-to-back
// requests flow at one word per cycle.
//
// Requests with a reserved opcode (and, when enabled, out-of-range
// immediates) are accepted but dropped: no word is produced, the address
// counter does not move, and the error flag / saturating error counter
// record the rejection.
//
// Parameters
//   BASE_ADDR   address assigned to the first word emitted after reset
//
// Ports
//   clk         sole clock, rising-edge
//   rst         synchronous, active-high reset
//   in_valid    request valid
//   in_ready    encoder can accept a request (!out_valid || out_ready)
//   in_op       00 LOAD, 01 STORE, 10 BRANCH, 11 reserved
//   in_rd       destination register (LOAD)
//   in_rs1      source register 1
//   in_rs2      source register 2 (STORE, BRANCH)
//   in_funct3   funct3 field
//   in_imm      signed immediate
//   out_valid   encoded word valid
//   out_ready   consumer accepts the word
//   out_instr   encoded instruction word
//   out_addr    address of out_instr
//   err_flag    sticky: at least one request rejected since reset
//   err_count   rejected requests, saturating at 255
//
// Build option
//   IMM_RANGE_CHECK_EN  when defined, immediates that do not fit their
//                       instruction format are rejected instead of being
//                       silently truncated.
// ----------------------------------------------------------------------------
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_flag,
    output logic [7:0]  err_count
);

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_STORE  = 2'b01,
        OP_BRANCH = 2'b10,
        OP_RSVD   = 2'b11
    } op_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] ADDR_STEP = 32'd4;
    localparam logic [7:0]  ERR_MAX   = 8'hFF;

    // ------------------------------------------------------------------
    // Format packers
    // ------------------------------------------------------------------
    function automatic logic [31:0] pack_i(
        input logic [11:0] imm,
        input logic [4:0]  rs1,
        input logic [2:0]  funct3,
        input logic [4:0]  rd
    );
        return {imm, rs1, funct3, rd, OPC_LOAD};
    endfunction

    function automatic logic [31:0] pack_s(
        input logic [11:0] imm,
        input logic [4:0]  rs2,
        input logic [4:0]  rs1,
        input logic [2:0]  funct3
    );
        return {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
    endfunction

    // Branch offsets are halfword aligned, so imm[0] has no slot in the word.
    function automatic logic [31:0] pack_b(
        input logic [12:1] imm,
        input logic [4:0]  rs2,
        input logic [4:0]  rs1,
        input logic [2:0]  funct3
    );
        return {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
    endfunction

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    op_t         op;
    logic        legal;
    logic [31:0] enc_word;
    logic        accept;
    logic        complete;
    logic        load_word;
    logic        reject;

    assign op = op_t'(in_op);

`ifdef IMM_RANGE_CHECK_EN
    // An immediate fits when every bit above the format's sign bit is a
    // copy of that sign bit (all zeros or all ones).
    logic imm_fits_12;
    logic imm_fits_13;

    assign imm_fits_12 = (in_imm[31:11] == '0) || (&in_imm[31:11]);
    assign imm_fits_13 = (in_imm[31:12] == '0) || (&in_imm[31:12]);
`else
    // Upper immediate bits are truncated away in this build.
    logic unused_imm_hi;

    assign unused_imm_hi = ^in_imm[31:13];
`endif

    // NOTE: every signal written in an always_comb gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        legal = 1'b1;
        case (op)
            OP_RSVD:   legal = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
            OP_LOAD,
            OP_STORE:  legal = imm_fits_12;
            OP_BRANCH: legal = imm_fits_13 && !in_imm[0];
`endif
            default:   legal = 1'b1;
        endcase
    end

    always_comb begin
        enc_word = '0;
        case (op)
            OP_LOAD:   enc_word = pack_i(in_imm[11:0], in_rs1, in_funct3, in_rd);
            OP_STORE:  enc_word = pack_s(in_imm[11:0], in_rs2, in_rs1, in_funct3);
            OP_BRANCH: enc_word = pack_b(in_imm[12:1], in_rs2, in_rs1, in_funct3);
            default:   enc_word = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    state_t state;

    // The register is free when empty or when its word leaves this cycle.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign complete  = out_valid && out_ready;
    assign load_word = accept && legal;
    assign reject    = accept && !legal;

    // ------------------------------------------------------------------
    // Output register, address counter, error tracking
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side reads the value from before this clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BASE_ADDR;
            err_flag  <= 1'b0;
            err_count <= '0;
        end else begin
            // The address names the word currently held, so it moves on
            // only when that word is consumed; rejected requests never
            // occupy an address.
            if (complete) begin
                out_addr <= out_addr + ADDR_STEP;
            end

            if (reject) begin
                err_flag <= 1'b1;
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + 8'd1;
                end
            end

            case (state)
                EMPTY: begin
                    if (load_word) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                        out_instr <= enc_word;
                    end
                end
                FULL: begin
                    // A legal accept while full implies out_ready, so the
                    // old word leaves on this edge and the new one replaces
                    // it without a bubble.
                    if (load_word) begin
                        out_instr <= enc_word;
                    end else if (complete) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// ----------------------------------------------------------------------------
// tb_inst_encoder
//
// Bench for inst_encoder. A transaction-level reference keeps the expected
// output word, its address and the error counters; encodings are computed
// from the field placement rules with shifts-by-multiplication and masks.
// Inputs change 1 ns after a rising edge, outputs are sampled 1 ns after it.
// ----------------------------------------------------------------------------
module tb_inst_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err_flag;
    logic [7:0]  err_count;

    int n_asserts = 0;
    int n_fails   = 0;

    // Reference state
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_addr;
    logic        m_err_flag;
    logic [7:0]  m_err_cnt;

    always #5 clk = ~clk;

    inst_encoder #(.BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err_flag  (err_flag),
        .err_count (err_count)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [31:0] ref_encode(
        input logic [1:0]  op,
        input logic [31:0] rd,
        input logic [31:0] rs1,
        input logic [31:0] rs2,
        input logic [31:0] f3,
        input logic [31:0] imm
    );
        case (op)
            2'b00: return (imm & 32'hFFF) * 32'h0010_0000 + rs1 * 32'h8000
                          + f3 * 32'h1000 + rd * 32'h80 + 32'h03;
            2'b01: return ((imm >> 5) & 32'h7F) * 32'h0200_0000 + rs2 * 32'h0010_0000
                          + rs1 * 32'h8000 + f3 * 32'h1000
                          + (imm & 32'h1F) * 32'h80 + 32'h23;
            2'b10: return ((imm >> 12) & 32'h1) * 32'h8000_0000
                          + ((imm >> 5) & 32'h3F) * 32'h0200_0000
                          + rs2 * 32'h0010_0000 + rs1 * 32'h8000 + f3 * 32'h1000
                          + ((imm >> 1) & 32'hF) * 32'h100
                          + ((imm >> 11) & 32'h1) * 32'h80 + 32'h63;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [1:0] op, input logic [31:0] imm);
`ifdef IMM_RANGE_CHECK_EN
        int s;
        s = $signed(imm);
        if (op == 2'b11) return 1'b0;
        if (op == 2'b10) return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
        return (s >= -2048) && (s <= 2047);
`else
        return op != 2'b11;
`endif
    endfunction

    // Advance DUT and reference by one clock using the inputs now driven.
    task automatic step();
        logic        nv;
        logic [31:0] ni;
        logic [31:0] na;
        logic        nf;
        logic [7:0]  nc;
        bit          rdy;
        bit          cmp;
        bit          acc;
        bit          lg;
        nv = m_valid; ni = m_instr; na = m_addr; nf = m_err_flag; nc = m_err_cnt;
        if (rst) begin
            nv = 1'b0; ni = 32'h0; na = BASE; nf = 1'b0; nc = 8'd0;
        end else begin
            rdy = !m_valid || out_ready;
            cmp = m_valid && out_ready;
            acc = in_valid && rdy;
            lg  = ref_legal(in_op, in_imm);
            if (cmp) begin
                na = m_addr + 32'd4;
                nv = 1'b0;
            end
            if (acc && lg) begin
                nv = 1'b1;
                ni = ref_encode(in_op, 32'(in_rd), 32'(in_rs1), 32'(in_rs2),
                                32'(in_funct3), in_imm);
            end
            if (acc && !lg) begin
                nf = 1'b1;
                if (nc < 8'd255) nc = nc + 8'd1;
            end
        end
        @(posedge clk);
        #1;
        m_valid = nv; m_instr = ni; m_addr = na; m_err_flag = nf; m_err_cnt = nc;
    endtask

    task automatic set_req(input logic v, input logic [1:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic [31:0] imm);
        in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_imm = imm;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        set_req(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
        step();
        step();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        n_asserts++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_asserts++; if (out_instr !== 32'h0) begin n_fails++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
        n_asserts++; if (out_addr !== BASE) begin n_fails++; $display("FAIL reset_addr got=%h exp=%h", out_addr, BASE); end
        n_asserts++; if (err_flag !== 1'b0) begin n_fails++; $display("FAIL reset_err_flag got=%b exp=0", err_flag); end
        n_asserts++; if (err_count !== 8'd0) begin n_fails++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        n_asserts++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_load();
        do_reset();
        set_req(1'b1, 2'b00, 5'd5, 5'd2, 5'd0, 3'b010, 32'hFFFF_FFFC);
        step();
        set_req(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
        n_asserts++; if (out_valid !== 1'b1) begin n_fails++; $display("FAIL load_valid got=%b exp=1", out_valid); end
        n_asserts++; if (out_instr !== 32'hFFC1_2283) begin n_fails++; $display("FAIL load_instr got=%h exp=ffc12283", out_instr); end
        n_asserts++; if (out_addr !== 32'h0) begin n_fails++; $display("FAIL load_addr got=%h exp=0", out_addr); end
        step();
        n_asserts++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL load_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_req(1'b1, 2'b01, 5'd0, 5'd2, 5'd7, 3'b010, 32'd8);
        step();
        n_asserts++; if (out_instr !== 32'h0071_2423 || out_addr !== 32'h0) begin
            n_fails++; $display("FAIL b2b_store got=%h@%h exp=00712423@0", out_instr, out_addr); end
        set_req(1'b1, 2'b10, 5'd0, 5'd1, 5'd2, 3'b000, 32'd16);
        #1;
        n_asserts++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        step();
        set_req(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
        n_asserts++; if (out_valid !== 1'b1) begin n_fails++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
        n_asserts++; if (out_instr !== 32'h0020_8863 || out_addr !== 32'h4) begin
            n_fails++; $display("FAIL b2b_branch got=%h@%h exp=00208863@4", out_instr, out_addr); end
        step();
        n_asserts++; if (out_valid !== 1'b0 || out_addr !== 32'h8) begin
            n_fails++; $display("FAIL b2b_drain got=%b@%h exp=0@8", out_valid, out_addr); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        set_req(1'b1, 2'b01, 5'd0, 5'd2, 5'd7, 3'b010, 32'd8);
        step();
        set_req(1'b1, 2'b10, 5'd0, 5'd1, 5'd2, 3'b000, 32'd16);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_asserts++; if (in_ready !== 1'b0) begin n_fails++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            n_asserts++; if (out_valid !== 1'b1 || out_instr !== 32'h0071_2423 || out_addr !== 32'h0) begin
                n_fails++; $display("FAIL bp_hold cyc=%0d got=%b %h@%h exp=1 00712423@0", i, out_valid, out_instr, out_addr); end
            step();
        end
        n_asserts++; if (out_instr !== 32'h0071_2423 || out_addr !== 32'h0) begin
            n_fails++; $display("FAIL bp_hold_last got=%h@%h exp=00712423@0", out_instr, out_addr); end
        out_ready = 1'b1;
        step();
        set_req(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
        n_asserts++; if (out_valid !== 1'b1 || out_instr !== 32'h0020_8863 || out_addr !== 32'h4) begin
            n_fails++; $display("FAIL bp_second got=%b %h@%h exp=1 00208863@4", out_valid, out_instr, out_addr); end
        step();
        n_asserts++; if (out_valid !== 1'b0 || out_addr !== 32'h8) begin
            n_fails++; $display("FAIL bp_drain got=%b@%h exp=0@8", out_valid, out_addr); end
    endtask

    task automatic test_imm_boundary();
        do_reset();
        set_req(1'b1, 2'b01, 5'd0, 5'd0, 5'd0, 3'd0, 32'd2048);
        step();
        set_req(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
`ifdef IMM_RANGE_CHECK_EN
        n_asserts++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL imm_rej_valid got=%b exp=0", out_valid); end
        n_asserts++; if (err_flag !== 1'b1 || err_count !== 8'd1) begin
            n_fails++; $display("FAIL imm_rej_err got=%b/%0d exp=1/1", err_flag, err_count); end
        // Largest positive LOAD immediate still fits and takes address 0.
        set_req(1'b1, 2'b00, 5'd1, 5'd3, 5'd0, 3'd0, 32'd2047);
        step();
        n_asserts++; if (out_valid !== 1'b1 || out_instr !== 32'h7FF1_8083 || out_addr !== 32'h0) begin
            n_fails++; $display("FAIL imm_max_load got=%b %h@%h exp=1 7ff18083@0", out_valid, out_instr, out_addr); end
        // Odd branch offset is rejected.
        set_req(1'b1, 2'b10, 5'd0, 5'd1, 5'd2, 3'd0, 32'd5);
        step();
        set_req(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
        n_asserts++; if (out_valid !== 1'b0 || err_count !== 8'd2 || out_addr !== 32'h4) begin
            n_fails++; $display("FAIL imm_odd_branch got=%b cnt=%0d @%h exp=0 cnt=2 @4", out_valid, err_count, out_addr); end
`else
        n_asserts++; if (out_valid !== 1'b1 || out_instr !== 32'h8000_0023 || out_addr !== 32'h0) begin
            n_fails++; $display("FAIL imm_trunc got=%b %h@%h exp=1 80000023@0", out_valid, out_instr, out_addr); end
        n_asserts++; if (err_flag !== 1'b0 || err_count !== 8'd0) begin
            n_fails++; $display("FAIL imm_trunc_err got=%b/%0d exp=0/0", err_flag, err_count); end
        step();
`endif
    endtask

    task automatic test_reserved_saturation();
        int exp_cnt;
        do_reset();
        for (int i = 0; i < 260; i++) begin
            set_req(1'b1, 2'b11, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), $urandom);
            step();
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            n_asserts++; if (out_valid !== 1'b0 || err_count !== 8'(exp_cnt)) begin
                n_fails++; $display("FAIL rsvd_cyc=%0d got valid=%b cnt=%0d exp valid=0 cnt=%0d", i, out_valid, err_count, exp_cnt); end
        end
        set_req(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
        n_asserts++; if (err_count !== 8'd255 || err_flag !== 1'b1 || out_addr !== BASE) begin
            n_fails++; $display("FAIL rsvd_final got cnt=%0d flag=%b @%h exp 255 1 @%h", err_count, err_flag, out_addr, BASE); end
    endtask

    task automatic test_random();
        logic [31:0] imm;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       imm = $urandom;
                1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                default: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            endcase
            set_req($urandom_range(0, 2) != 0,
                    ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                    5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm);
            #1;
            n_asserts++; if (!rst && in_ready !== (!m_valid || out_ready)) begin
                n_fails++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", i, in_ready, !m_valid || out_ready); end
            step();
            n_asserts++; if (out_valid !== m_valid) begin n_fails++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, out_valid, m_valid); end
            n_asserts++; if (m_valid && out_instr !== m_instr) begin n_fails++; $display("FAIL rand_instr cyc=%0d got=%h exp=%h", i, out_instr, m_instr); end
            n_asserts++; if (out_addr !== m_addr) begin n_fails++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", i, out_addr, m_addr); end
            n_asserts++; if (err_flag !== m_err_flag || err_count !== m_err_cnt) begin
                n_fails++; $display("FAIL rand_err cyc=%0d got=%b/%0d exp=%b/%0d", i, err_flag, err_count, m_err_flag, m_err_cnt); end
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(1'b1, 2'b11, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 2'b00, 5'(i + 1), 5'd4, 5'd0, 3'd3, 32'(i * 4));
            step();
        end
        n_asserts++; if (out_valid !== 1'b1 || out_addr !== 32'h8 || err_count !== 8'd1) begin
            n_fails++; $display("FAIL mid_pre got=%b @%h cnt=%0d exp=1 @8 cnt=1", out_valid, out_addr, err_count); end
        rst = 1'b1;
        set_req(1'b1, 2'b01, 5'd0, 5'd1, 5'd1, 3'd0, 32'd4);
        step();
        rst = 1'b0;
        set_req(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
        #1;
        n_asserts++; if (out_valid !== 1'b0 || out_addr !== BASE) begin
            n_fails++; $display("FAIL mid_rst got=%b @%h exp=0 @%h", out_valid, out_addr, BASE); end
        n_asserts++; if (err_count !== 8'd0 || err_flag !== 1'b0) begin
            n_fails++; $display("FAIL mid_rst_err got=%0d/%b exp=0/0", err_count, err_flag); end
        n_asserts++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        set_req(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
        m_valid = 1'b0; m_instr = 32'h0; m_addr = BASE; m_err_flag = 1'b0; m_err_cnt = 8'd0;

        test_reset();
        test_load();
        test_back_to_back();
        test_backpressure();
        test_imm_boundary();
        test_reserved_saturation();
        test_random();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, meaning: address assigned to the first emitted instruction after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  encoder can accept a request.
REQ-006 in_op  input  2  00 LOAD (7'b0000011), 01 STORE (7'b0100011), 10 BRANCH (7'b1100011), 11 reserved.
REQ-007 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-008 in_funct3  input  3  funct3 field.
REQ-009 in_imm  input  32  signed immediate to pack.
REQ-010 out_valid  output  1  encoded instruction valid.
REQ-011 out_ready  input  1  consumer accepts instruction.
REQ-012 out_instr  output  32  encoded instruction word.
REQ-013 out_addr  output  32  address of out_instr.
REQ-014 err_flag  output  1  sticky: at least one request rejected since reset.
REQ-015 err_count  output  8  number of rejected requests, saturating at 255.

Function
REQ-016 Request accepted when in_valid && in_ready; response completes when out_valid && out_ready.
REQ-017 One output register; in_ready = !out_valid || out_ready (full throughput, no bubble when consumer ready).
REQ-018 Latency: out_valid asserts the cycle after acceptance of a legal request.
REQ-019 While out_valid && !out_ready, out_instr and out_addr held stable.
REQ-020 LOAD encoding: {imm[11:0], rs1, funct3, rd, 7'b0000011}.
REQ-021 STORE encoding: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}.
REQ-022 BRANCH encoding: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}; imm[0] discarded.
REQ-023 Reserved in_op: accepted, no output produced, err_flag set, err_count incremented.
REQ-024 out_addr starts at BASE_ADDR; advances by 4 on each completed output handshake; wraps modulo 2^32.
REQ-025 Rejected requests do not advance out_addr.
REQ-026 Simultaneous output handshake and legal acceptance: register reloaded same edge, address advanced by 4, out_valid stays 1.
REQ-027 Simultaneous output handshake and rejected acceptance: out_valid drops to 0, address advanced by 4, error counted.
REQ-028 State machine: EMPTY (out_valid=0), FULL (out_valid=1); EMPTY->FULL on legal accept; FULL->EMPTY on output handshake without legal accept; otherwise hold.

Reset
REQ-029 On rst: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_flag=0, err_count=0, state EMPTY.
REQ-030 rst mid-operation discards any held instruction; rst overrides all simultaneous handshakes.
REQ-031 in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-032 Macro IMM_RANGE_CHECK_EN.
REQ-033 Defined: LOAD/STORE require in_imm[31:11] all equal; BRANCH requires in_imm[31:12] all equal and in_imm[0]=0; violations are rejected per REQ-023.
REQ-034 Undefined: no range check; upper immediate bits silently truncated per REQ-020..022; only reserved in_op is rejected.

Verification
REQ-035 LOAD rd=5 rs1=2 funct3=010 imm=0xFFFFFFFC, out_ready=1 -> next cycle out_instr=0xFFC12283, out_addr=0x0.
REQ-036 STORE rs1=2 rs2=7 funct3=010 imm=8 then BRANCH rs1=1 rs2=2 funct3=000 imm=16 back-to-back -> 0x00712423 @0x0, then 0x00208863 @0x4.
REQ-037 out_ready=0 for 3 cycles with second request pending -> in_ready=0, first word held stable; release -> both emitted in order at 0x0, 0x4.
REQ-038 STORE imm=2048: with IMM_RANGE_CHECK_EN -> no out_valid, err_flag=1, err_count=1, next address still 0x0; without -> emitted 0x80000023-pattern with imm[11:0]=0x800.
REQ-039 in_op=11 repeated 260 times -> err_count=255, err_flag=1, out_valid never asserts.
REQ-040 rst asserted while out_valid=1 and out_addr=0x8 -> next cycle out_valid=0, out_addr=BASE_ADDR, err_count=0, in_ready=1.
